reg_file: RTL and testbench
===========================

// Module: reg_file
//
// PURPOSE
// 32-entry general-purpose register file for the single-cycle datapath.
// Two read ports supply operand A and operand B to the execute stage (ALU/shifter inA, inB).
// One write port accepts the writeback result (ALU/shifter out) on the rising clock edge.
// Write-through bypass: an operand read in the same cycle as a write to that register sees the new value.
//
// PARAMETERS
// DATA_WIDTH  32  width of each register and of every data port
// ADDR_WIDTH  5   register index width; depth = 2**ADDR_WIDTH
// ZERO_REG    1   1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary storage
//
// PORTS
// clk       input   1           single clock; all state updates on rising edge
// rst_n     input   1           asynchronous, active-low reset
// rs1_addr  input   ADDR_WIDTH  read port 1 index (operand A)
// rs2_addr  input   ADDR_WIDTH  read port 2 index (operand B)
// rs1_data  output  DATA_WIDTH  read port 1 data
// rs2_data  output  DATA_WIDTH  read port 2 data
// wr_en     input   1           write enable for this cycle
// wr_addr   input   ADDR_WIDTH  write index
// wr_data   input   DATA_WIDTH  write data (writeback result)
//
// BEHAVIOUR
// - Reset: rst_n low clears all registers to 0 immediately, without waiting for a clock edge.
//   - While rst_n is low, rs1_data and rs2_data are 0 and writes are ignored.
//   - Reset asserted mid-cycle discards any pending write. Reset wins over a write on the same edge.
// - Write: on a rising clk edge with rst_n high and wr_en = 1, regs[wr_addr] <= wr_data.
//   - When ZERO_REG = 1, a write to wr_addr = 0 is dropped.
//   - wr_en = 0 leaves every register unchanged, whatever wr_addr and wr_data are.
// - Read: combinational, zero-cycle latency; rsN_data follows rsN_addr within the same cycle.
// - Read priority, per port, highest first:
//   1. ZERO_REG = 1 and rsN_addr = 0: output 0, even if a write to 0 is presented.
//   2. wr_en = 1 and wr_addr = rsN_addr: output wr_data (bypass of the write that lands at the next edge).
//   3. Otherwise: output regs[rsN_addr].
// - Both ports may address the same register; both return identical data, bypass included.
// - Both ports bypass independently when both match wr_addr.
// - Full index range 0..2**ADDR_WIDTH-1 is valid; there is no out-of-range case.
// - X/Z on wr_addr while wr_en = 0 must not corrupt state.
// - No internal FSM; state is the register array only.
// - Outputs change only on address, write-port or reset changes, or after a write edge.
//
// TESTING
// Use DATA_WIDTH = 32, ADDR_WIDTH = 5, ZERO_REG = 1 unless a scenario states otherwise.
// 1. Reset then read: pulse rst_n low, read all 32 indices on both ports -> every read returns 32'h0.
// 2. Write/read: write 32'hDEADBEEF to r5 and 32'h00000010 to r6, then read rs1 = 5, rs2 = 6
//    -> rs1_data = DEADBEEF, rs2_data = 00000010 on the next cycle.
// 3. Bypass: in one cycle set wr_en = 1, wr_addr = 7, wr_data = 32'h12345678, rs1 = 7, rs2 = 7
//    -> both outputs equal 12345678 in that same cycle and still hold it after the edge.
// 4. Zero register: write 32'hFFFFFFFF to r0, with rs1 = 0 during and after the write
//    -> rs1_data stays 0. Repeat with ZERO_REG = 0 -> r0 reads FFFFFFFF after the edge.
// 5. Write-enable gating: wr_en = 0, wr_addr = 3, wr_data = 32'hAAAA5555 across 3 edges -> r3 keeps its prior value.
// 6. Async reset mid-op: with r9 = 32'h0000CAFE, drop rst_n between edges while wr_en = 1 targets r9
//    -> r9 reads 0 at once, before any edge. The write is discarded.
//    -> After rst_n rises, r9 is still 0 until a new write.

Source files
------------

// File: rtl/reg_file.sv
// 32-entry register file: two combinational read ports, one write port.
// Reads bypass the pending write; register 0 optionally hardwired to zero.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic                  wr_ok;

    // A write lands only when enabled and not aimed at a hardwired zero.
    always_comb begin
        wr_ok = wr_en;
        if (ZERO_REG && (wr_addr == '0)) begin
            wr_ok = 1'b0;
        end
    end

    // Next-state array: current contents with the accepted write merged in.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Register array; reset clears every entry without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read port 1: zero register, then bypass, then stored value.
    always_comb begin
        rs1_data = regs_q[rs1_addr];
        if (wr_en && (wr_addr == rs1_addr)) begin
            rs1_data = wr_data;
        end
        if (ZERO_REG && (rs1_addr == '0)) begin
            rs1_data = '0;
        end
        if (!rst_n) begin
            rs1_data = '0;
        end
    end

    // Read port 2: same priority as port 1, evaluated independently.
    always_comb begin
        rs2_data = regs_q[rs2_addr];
        if (wr_en && (wr_addr == rs2_addr)) begin
            rs2_data = wr_data;
        end
        if (ZERO_REG && (rs2_addr == '0)) begin
            rs2_data = '0;
        end
        if (!rst_n) begin
            rs2_data = '0;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file.
// A second instance with the zero register disabled shares the inputs.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] z_rs1_data;
    logic [31:0] z_rs2_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int passed;
    int total;

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(z_rs1_data), .rs2_data(z_rs2_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        wr_addr = 5'd0;
        wr_data = 32'h0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            total++;
            if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
                $display("FAIL reset_read idx %0d: got %h/%h want 0", i, rs1_data, rs2_data);
            end else passed++;
            total++;
            if (z_rs1_data !== 32'h0 || z_rs2_data !== 32'h0) begin
                $display("FAIL reset_read_nz idx %0d: got %h/%h want 0", i, z_rs1_data, z_rs2_data);
            end else passed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        do_write(5'd5, 32'hDEADBEEF);
        do_write(5'd6, 32'h00000010);
        rs1_addr = 5'd5;
        rs2_addr = 5'd6;
        #1;
        total++;
        if (rs1_data !== 32'hDEADBEEF) begin
            $display("FAIL write_read_r5: got %h want DEADBEEF", rs1_data);
        end else passed++;
        total++;
        if (rs2_data !== 32'h00000010) begin
            $display("FAIL write_read_r6: got %h want 00000010", rs2_data);
        end else passed++;
        total++;
        if (z_rs1_data !== 32'hDEADBEEF) begin
            $display("FAIL write_read_nz_r5: got %h want DEADBEEF", z_rs1_data);
        end else passed++;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = 5'd7;
        wr_data = 32'h12345678;
        rs1_addr = 5'd7;
        rs2_addr = 5'd7;
        #1;
        total++;
        if (rs1_data !== 32'h12345678 || rs2_data !== 32'h12345678) begin
            $display("FAIL bypass_same_cycle: got %h/%h want 12345678", rs1_data, rs2_data);
        end else passed++;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        wr_data = 32'h0;
        #1;
        total++;
        if (rs1_data !== 32'h12345678 || rs2_data !== 32'h12345678) begin
            $display("FAIL bypass_after_edge: got %h/%h want 12345678", rs1_data, rs2_data);
        end else passed++;
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = 5'd0;
        wr_data = 32'hFFFFFFFF;
        rs1_addr = 5'd0;
        #1;
        total++;
        if (rs1_data !== 32'h0) begin
            $display("FAIL zero_during_write: got %h want 0", rs1_data);
        end else passed++;
        total++;
        if (z_rs1_data !== 32'hFFFFFFFF) begin
            $display("FAIL nz_r0_bypass: got %h want FFFFFFFF", z_rs1_data);
        end else passed++;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        wr_data = 32'h0;
        #1;
        total++;
        if (rs1_data !== 32'h0) begin
            $display("FAIL zero_after_write: got %h want 0", rs1_data);
        end else passed++;
        total++;
        if (z_rs1_data !== 32'hFFFFFFFF) begin
            $display("FAIL nz_r0_stored: got %h want FFFFFFFF", z_rs1_data);
        end else passed++;
    endtask

    task automatic test_wr_en_gating();
        do_write(5'd3, 32'h11112222);
        @(negedge clk);
        wr_en = 1'b0;
        wr_addr = 5'd3;
        wr_data = 32'hAAAA5555;
        rs1_addr = 5'd3;
        rs2_addr = 5'd5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (rs1_data !== 32'h11112222) begin
                $display("FAIL wr_en_gate edge %0d: got %h want 11112222", i, rs1_data);
            end else passed++;
        end
        wr_addr = 'x;
        @(posedge clk);
        #1;
        wr_addr = 5'd0;
        #1;
        total++;
        if (rs1_data !== 32'h11112222 || rs2_data !== 32'hDEADBEEF) begin
            $display("FAIL x_addr_gate: got %h/%h want 11112222/DEADBEEF", rs1_data, rs2_data);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        do_write(5'd10, 32'hA5A5A5A5);
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = 5'd11;
        wr_data = 32'h5A5A5A5A;
        rs1_addr = 5'd10;
        rs2_addr = 5'd11;
        #1;
        total++;
        if (rs1_data !== 32'hA5A5A5A5 || rs2_data !== 32'h5A5A5A5A) begin
            $display("FAIL b2b_during: got %h/%h want A5A5A5A5/5A5A5A5A", rs1_data, rs2_data);
        end else passed++;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        #1;
        total++;
        if (rs1_data !== 32'hA5A5A5A5 || rs2_data !== 32'h5A5A5A5A) begin
            $display("FAIL b2b_after: got %h/%h want A5A5A5A5/5A5A5A5A", rs1_data, rs2_data);
        end else passed++;
    endtask

    task automatic test_async_reset();
        do_write(5'd9, 32'h0000CAFE);
        rs1_addr = 5'd9;
        rs2_addr = 5'd5;
        #1;
        total++;
        if (rs1_data !== 32'h0000CAFE) begin
            $display("FAIL ar_preload: got %h want 0000CAFE", rs1_data);
        end else passed++;
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = 5'd9;
        wr_data = 32'h12345678;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            $display("FAIL ar_immediate: got %h/%h want 0", rs1_data, rs2_data);
        end else passed++;
        @(posedge clk);
        #1;
        total++;
        if (rs1_data !== 32'h0) begin
            $display("FAIL ar_held: got %h want 0", rs1_data);
        end else passed++;
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        #1;
        total++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            $display("FAIL ar_released: got %h/%h want 0", rs1_data, rs2_data);
        end else passed++;
        @(posedge clk);
        #1;
        total++;
        if (rs1_data !== 32'h0) begin
            $display("FAIL ar_write_dropped: got %h want 0", rs1_data);
        end else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        rst_n = 1'b0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        wr_en = 1'b0;
        wr_addr = 5'd0;
        wr_data = 32'h0;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_wr_en_gating();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
